// File: rtl/fetch_bp_if.sv
// fetch_bp_if: fetch-stage bus between the pipeline control/execute side and fetch_bp.
interface fetch_bp_if #(parameter int XLEN = 32);
    logic            f_stall;
    logic            e_redirect;
    logic [XLEN-1:0] e_redirect_pc;
    logic            e_br_valid;
    logic [XLEN-1:0] e_br_pc;
    logic            e_br_taken;
    logic [XLEN-1:0] e_br_target;
    logic [XLEN-1:0] f_pc;
    logic [XLEN-1:0] f_pc_plus_4;
    logic            f_pred_taken;
    logic [XLEN-1:0] f_pred_target;
    modport master (
        output f_stall, e_redirect, e_redirect_pc, e_br_valid, e_br_pc, e_br_taken, e_br_target,
        input  f_pc, f_pc_plus_4, f_pred_taken, f_pred_target
    );
    modport slave (
        input  f_stall, e_redirect, e_redirect_pc, e_br_valid, e_br_pc, e_br_taken, e_br_target,
        output f_pc, f_pc_plus_4, f_pred_taken, f_pred_target
    );
endinterface

// File: rtl/fetch_bp.sv
// fetch_bp: fetch PC register with a direct-mapped BTB and 2-bit saturating predictor.
module fetch_bp #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              BTB_ENTRIES = 16
) (
    input logic       clk,
    input logic       reset,
    fetch_bp_if.slave bus
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    if (BTB_ENTRIES < 2 || (BTB_ENTRIES & (BTB_ENTRIES - 1)) != 0) begin : g_bad_entries
        $error("fetch_bp: BTB_ENTRIES must be a power of 2 and >= 2");
    end

    logic [XLEN-1:0]  pc_q, pc_d;
    logic             valid_q [BTB_ENTRIES];
    logic             valid_d [BTB_ENTRIES];
    logic [TAG_W-1:0] tag_q   [BTB_ENTRIES];
    logic [TAG_W-1:0] tag_d   [BTB_ENTRIES];
    logic [XLEN-1:0]  tgt_q   [BTB_ENTRIES];
    logic [XLEN-1:0]  tgt_d   [BTB_ENTRIES];
    logic [1:0]       ctr_q   [BTB_ENTRIES];
    logic [1:0]       ctr_d   [BTB_ENTRIES];

    logic [IDX_W-1:0] f_idx, e_idx;
    logic [TAG_W-1:0] f_tag, e_tag;
    logic             f_hit, e_hit;
    logic             unused_ok;

    assign f_idx     = pc_q[IDX_W+1:2];
    assign f_tag     = pc_q[XLEN-1:IDX_W+2];
    assign e_idx     = bus.e_br_pc[IDX_W+1:2];
    assign e_tag     = bus.e_br_pc[XLEN-1:IDX_W+2];
    assign f_hit     = valid_q[f_idx] && tag_q[f_idx] == f_tag;
    assign e_hit     = valid_q[e_idx] && tag_q[e_idx] == e_tag;
    assign unused_ok = &{1'b0, bus.e_br_pc[1:0]};

    assign bus.f_pc          = pc_q;
    assign bus.f_pc_plus_4   = pc_q + XLEN'(4);
    assign bus.f_pred_taken  = f_hit && ctr_q[f_idx][1];
    assign bus.f_pred_target = bus.f_pred_taken ? tgt_q[f_idx] : bus.f_pc_plus_4;

    always_comb begin
        pc_d    = bus.e_redirect ? bus.e_redirect_pc : bus.f_stall ? pc_q : bus.f_pred_target;
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        if (bus.e_br_valid && e_hit) begin
            ctr_d[e_idx] = bus.e_br_taken ? (ctr_q[e_idx] == 2'b11 ? 2'b11 : ctr_q[e_idx] + 2'b01)
                                          : (ctr_q[e_idx] == 2'b00 ? 2'b00 : ctr_q[e_idx] - 2'b01);
            tgt_d[e_idx] = bus.e_br_taken ? bus.e_br_target : tgt_q[e_idx];
        end else if (bus.e_br_valid && bus.e_br_taken) begin
            valid_d[e_idx] = 1'b1;
            tag_d[e_idx]   = e_tag;
            tgt_d[e_idx]   = bus.e_br_target;
            ctr_d[e_idx]   = 2'b10;
        end
    end

    // Tags and targets need no reset: they are only observed through a set valid bit.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
        if (reset) begin
            pc_q    <= RESET_PC;
            valid_q <= '{default: 1'b0};
            ctr_q   <= '{default: 2'b01};
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
        end
    end
endmodule

// File: tb/tb_fetch_bp.sv
// tb_fetch_bp: directed scoreboard bench for fetch_bp (RESET_PC=0x100, 16-entry BTB).
module tb_fetch_bp;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tgt;
    } exp_t;

    exp_t sb[$];

    fetch_bp_if #(.XLEN(32)) bus ();

    fetch_bp #(.XLEN(32), .RESET_PC(32'h100), .BTB_ENTRIES(16)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic drv(input logic stall, input logic redir, input logic [31:0] rpc,
                       input logic bv, input logic [31:0] bpc, input logic bt, input logic [31:0] btgt);
        bus.f_stall       = stall;
        bus.e_redirect    = redir;
        bus.e_redirect_pc = rpc;
        bus.e_br_valid    = bv;
        bus.e_br_pc       = bpc;
        bus.e_br_taken    = bt;
        bus.e_br_target   = btgt;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic cyc(input string tag, input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
        exp_t e;
        logic [31:0] p4;
        sb.push_back('{tag, pc, pt, tgt});
        @(posedge clk);
        #1;
        e  = sb.pop_front();
        p4 = e.pc + 32'd4;
        tests++;
        assert (bus.f_pc === e.pc) else begin
            fails++;
            $error("FAIL %s f_pc got %h exp %h", e.tag, bus.f_pc, e.pc);
        end
        tests++;
        assert (bus.f_pc_plus_4 === p4) else begin
            fails++;
            $error("FAIL %s f_pc_plus_4 got %h exp %h", e.tag, bus.f_pc_plus_4, p4);
        end
        tests++;
        assert (bus.f_pred_taken === e.pt) else begin
            fails++;
            $error("FAIL %s f_pred_taken got %b exp %b", e.tag, bus.f_pred_taken, e.pt);
        end
        tests++;
        assert (bus.f_pred_target === e.tgt) else begin
            fails++;
            $error("FAIL %s f_pred_target got %h exp %h", e.tag, bus.f_pred_target, e.tgt);
        end
    endtask

    initial begin
        idle();
        reset = 1'b1;
        cyc("rst", 32'h100, 1'b0, 32'h104);
        reset = 1'b0;
        cyc("seq1", 32'h104, 1'b0, 32'h108);
        cyc("seq2", 32'h108, 1'b0, 32'h10C);
        cyc("seq3", 32'h10C, 1'b0, 32'h110);
        // Train 0x108 taken while looping back to it: the write is visible right after the edge.
        drv(1'b0, 1'b1, 32'h108, 1'b1, 32'h108, 1'b1, 32'h200);
        cyc("alloc", 32'h108, 1'b1, 32'h200);
        idle();
        cyc("follow", 32'h200, 1'b0, 32'h204);
        drv(1'b0, 1'b1, 32'h108, 1'b1, 32'h108, 1'b0, 32'hDEAD0);
        cyc("nt_10to01", 32'h108, 1'b0, 32'h10C);
        drv(1'b0, 1'b1, 32'h108, 1'b1, 32'h108, 1'b1, 32'h200);
        cyc("t_01to10", 32'h108, 1'b1, 32'h200);
        cyc("t_10to11", 32'h108, 1'b1, 32'h200);
        cyc("t_11sat", 32'h108, 1'b1, 32'h200);
        drv(1'b0, 1'b1, 32'h108, 1'b1, 32'h108, 1'b0, 32'hDEAD0);
        cyc("nt_11to10", 32'h108, 1'b1, 32'h200);
        cyc("nt_10to01b", 32'h108, 1'b0, 32'h10C);
        cyc("nt_01to00", 32'h108, 1'b0, 32'h10C);
        cyc("nt_00sat", 32'h108, 1'b0, 32'h10C);
        drv(1'b0, 1'b1, 32'h108, 1'b1, 32'h108, 1'b1, 32'h200);
        cyc("t_00to01", 32'h108, 1'b0, 32'h10C);
        cyc("t_01to10b", 32'h108, 1'b1, 32'h200);
        drv(1'b1, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0);
        cyc("redir_over_stall", 32'h300, 1'b0, 32'h304);
        drv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        cyc("stall1", 32'h300, 1'b0, 32'h304);
        cyc("stall2", 32'h300, 1'b0, 32'h304);
        idle();
        cyc("unstall", 32'h304, 1'b0, 32'h308);
        drv(1'b0, 1'b1, 32'h108, 1'b1, 32'h148, 1'b1, 32'h400);
        cyc("alias_miss", 32'h108, 1'b0, 32'h10C);
        drv(1'b0, 1'b1, 32'h148, 1'b0, 32'h0, 1'b0, 32'h0);
        cyc("alias_hit", 32'h148, 1'b1, 32'h400);
        idle();
        cyc("alias_follow", 32'h400, 1'b0, 32'h404);
        drv(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
        cyc("wrap_top", 32'hFFFF_FFFC, 1'b0, 32'h0);
        idle();
        cyc("wrap_zero", 32'h0, 1'b0, 32'h4);
        reset = 1'b1;
        drv(1'b1, 1'b1, 32'h300, 1'b1, 32'h108, 1'b1, 32'h200);
        cyc("rst_wins", 32'h100, 1'b0, 32'h104);
        reset = 1'b0;
        drv(1'b0, 1'b1, 32'h148, 1'b0, 32'h0, 1'b0, 32'h0);
        cyc("rst_miss148", 32'h148, 1'b0, 32'h14C);
        drv(1'b0, 1'b1, 32'h108, 1'b0, 32'h0, 1'b0, 32'h0);
        cyc("rst_miss108", 32'h108, 1'b0, 32'h10C);
        idle();
        cyc("rst_seq", 32'h10C, 1'b0, 32'h110);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
